unary_bitstream_decoder: RTL and testbench

- Converts a unary (stochastic) bitstream back to binary by counting ones over a fixed window of 2^BITWIDTH enabled samples.
- Closes the loop with the sobolrng plus comparator encoder: the encoder produces a bitstream of 2^BITWIDTH samples, and this block recovers the encoded value.
- Results leave through a single-entry valid/ready output register. A sticky flag reports any result that was lost.

---
 rtl/unary_bitstream_decoder.sv | 105 ++++++++++
 tb/tb_unary_bitstream_decoder.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/unary_bitstream_decoder.sv
// Unary bitstream decoder: counts ones over 2^BITWIDTH enabled samples and
// presents the saturated count through a single-entry valid/ready register.
module unary_bitstream_decoder #(
  parameter int BITWIDTH = 8
) (
  input  logic                iClk,
  input  logic                iRst,
  input  logic                iEn,
  input  logic                iClr,
  input  logic                iBit,
  input  logic                iReady,
  output logic [BITWIDTH-1:0] oData,
  output logic                oValid,
  output logic                oOvf,
  output logic                oBusy
);

  // state | meaning
  // IDLE  | no window open, counters at zero
  // ACCUM | at least one sample taken in the current window
  typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

  state_t state_q, state_d;

  logic [BITWIDTH-1:0] cnt_q, cnt_d;
  logic [BITWIDTH:0]   acc_q, acc_d;
  logic [BITWIDTH-1:0] data_q, data_d;
  logic                valid_q, valid_d;
  logic                ovf_q, ovf_d;

  logic                sample;
  logic                win_end;
  logic                xfer;
  logic [BITWIDTH:0]   sum;
  logic [BITWIDTH-1:0] result;

  assign sample  = iEn & ~iClr;
  assign win_end = sample & (cnt_q == {BITWIDTH{1'b1}});
  assign xfer    = valid_q & iReady;
  assign sum     = acc_q + {{BITWIDTH{1'b0}}, iBit};
  // A window of all ones counts 2^BITWIDTH, which does not fit; clamp it.
  assign result  = sum[BITWIDTH] ? {BITWIDTH{1'b1}} : sum[BITWIDTH-1:0];

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (iClr) begin
      state_d = IDLE;
    end else if (iEn) begin
      state_d = win_end ? IDLE : ACCUM;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    if (xfer) begin
      valid_d = 1'b0;
    end
    if (iClr) begin
      cnt_d = '0;
      acc_d = '0;
    end else if (iEn) begin
      if (win_end) begin
        cnt_d   = '0;
        acc_d   = '0;
        data_d  = result;
        valid_d = 1'b1;
        // Overwriting a result nobody took this cycle loses it.
        if (valid_q && !iReady) begin
          ovf_d = 1'b1;
        end
      end else begin
        cnt_d = cnt_q + 1'b1;
        acc_d = sum;
      end
    end
  end

  assign oData  = data_q;
  assign oValid = valid_q;
  assign oOvf   = ovf_q;
  assign oBusy  = (state_q == ACCUM);

endmodule

// File: tb/tb_unary_bitstream_decoder.sv
// Directed bench for unary_bitstream_decoder: a BITWIDTH=4 instance for the
// window/handshake cases and a BITWIDTH=8 instance fed by a Sobol comparator.
module tb_unary_bitstream_decoder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst4 = 1'b0, en4 = 1'b0, clr4 = 1'b0, bit4 = 1'b0, rdy4 = 1'b0;
  logic [3:0] data4;
  logic       valid4, ovf4, busy4;

  logic       rst8 = 1'b0, en8 = 1'b0, clr8 = 1'b0, bit8 = 1'b0, rdy8 = 1'b0;
  logic [7:0] data8;
  logic       valid8, ovf8, busy8;

  int errors = 0;
  int checks = 0;

  unary_bitstream_decoder #(.BITWIDTH(4)) u4 (
    .iClk(clk), .iRst(rst4), .iEn(en4), .iClr(clr4), .iBit(bit4),
    .iReady(rdy4), .oData(data4), .oValid(valid4), .oOvf(ovf4), .oBusy(busy4)
  );

  unary_bitstream_decoder #(.BITWIDTH(8)) u8 (
    .iClk(clk), .iRst(rst8), .iEn(en8), .iClr(clr8), .iBit(bit8),
    .iReady(rdy8), .oData(data8), .oValid(valid8), .oOvf(ovf8), .oBusy(busy8)
  );

  // Drive one cycle of inputs, then settle 1 time unit past the edge.
  task automatic step4(input logic en, input logic clr, input logic b, input logic rdy);
    en4 = en; clr4 = clr; bit4 = b; rdy4 = rdy;
    @(posedge clk); #1;
  endtask

  task automatic step8(input logic en, input logic b, input logic rdy);
    en8 = en; clr8 = 1'b0; bit8 = b; rdy8 = rdy;
    @(posedge clk); #1;
  endtask

  task automatic win4(input logic [15:0] pat, input logic rdy);
    for (int i = 0; i < 16; i++) step4(1'b1, 1'b0, pat[i], rdy);
  endtask

  function automatic logic [7:0] sobol8(input int idx);
    logic [7:0] g;
    logic [7:0] r;
    g = 8'(idx ^ (idx >> 1));
    for (int k = 0; k < 8; k++) r[k] = g[7-k];
    return r;
  endfunction

  task automatic test_reset;
    rst4 = 1'b1; rst8 = 1'b1;
    en4 = 1'b1; bit4 = 1'b1; en8 = 1'b1; bit8 = 1'b1;
    @(posedge clk); #1;
    rst4 = 1'b0; rst8 = 1'b0; en4 = 1'b0; en8 = 1'b0;
    checks++; if (data4 !== 4'd0) begin errors++; $display("FAIL reset_data4 got=%0d exp=0", data4); end
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL reset_valid4 got=%b exp=0", valid4); end
    checks++; if (ovf4 !== 1'b0) begin errors++; $display("FAIL reset_ovf4 got=%b exp=0", ovf4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL reset_busy4 got=%b exp=0", busy4); end
    checks++; if (data8 !== 8'd0) begin errors++; $display("FAIL reset_data8 got=%0d exp=0", data8); end
    checks++; if (valid8 !== 1'b0 || ovf8 !== 1'b0 || busy8 !== 1'b0) begin
      errors++; $display("FAIL reset_flags8 got=%b%b%b exp=000", valid8, ovf8, busy8);
    end
  endtask

  task automatic test_saturate;
    for (int i = 0; i < 16; i++) begin
      step4(1'b1, 1'b0, 1'b1, 1'b1);
      checks++;
      if (valid4 !== (i == 15)) begin errors++; $display("FAIL sat_valid step=%0d got=%b exp=%b", i, valid4, (i == 15)); end
    end
    checks++; if (data4 !== 4'd15) begin errors++; $display("FAIL sat_data got=%0d exp=15", data4); end
    checks++; if (ovf4 !== 1'b0) begin errors++; $display("FAIL sat_ovf got=%b exp=0", ovf4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL sat_busy_end got=%b exp=0", busy4); end
    step4(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL sat_valid_pulse got=%b exp=0", valid4); end
  endtask

  task automatic test_back_to_back;
    win4(16'h5555, 1'b1);
    checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL b2b_valid1 got=%b exp=1", valid4); end
    checks++; if (data4 !== 4'd8) begin errors++; $display("FAIL b2b_data1 got=%0d exp=8", data4); end
    for (int i = 0; i < 16; i++) begin
      step4(1'b1, 1'b0, 1'b0, 1'b1);
      checks++;
      if (valid4 !== (i == 15)) begin errors++; $display("FAIL b2b_valid2 step=%0d got=%b exp=%b", i, valid4, (i == 15)); end
    end
    checks++; if (data4 !== 4'd0) begin errors++; $display("FAIL b2b_data2 got=%0d exp=0", data4); end
  endtask

  task automatic test_enable_gaps;
    logic [15:0] mask;
    mask = 16'h1249;
    for (int i = 0; i < 16; i++) begin
      step4(1'b1, 1'b0, mask[i], 1'b1);
      checks++;
      if (busy4 !== (i != 15)) begin errors++; $display("FAIL gap_busy sample=%0d got=%b exp=%b", i, busy4, (i != 15)); end
      if (i < 10) begin
        step4(1'b0, 1'b0, 1'b1, 1'b1);
        checks++;
        if (busy4 !== 1'b1) begin errors++; $display("FAIL gap_busy_hold after=%0d got=%b exp=1", i, busy4); end
      end
    end
    checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL gap_valid got=%b exp=1", valid4); end
    checks++; if (data4 !== 4'd5) begin errors++; $display("FAIL gap_data got=%0d exp=5", data4); end
  endtask

  task automatic test_clear;
    logic [15:0] pat;
    int          nvalid;
    logic [3:0]  seen;
    pat = 16'h4084;
    nvalid = 0;
    seen = 4'hx;
    for (int i = 0; i < 7; i++) step4(1'b1, 1'b0, 1'b1, 1'b1);
    step4(1'b1, 1'b1, 1'b1, 1'b1);
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL clr_busy got=%b exp=0", busy4); end
    for (int i = 0; i < 17; i++) begin
      if (i < 16) step4(1'b1, 1'b0, pat[i], 1'b1);
      else        step4(1'b0, 1'b0, 1'b0, 1'b1);
      if (valid4 === 1'b1) begin nvalid++; seen = data4; end
    end
    checks++; if (nvalid != 1) begin errors++; $display("FAIL clr_valid_count got=%0d exp=1", nvalid); end
    checks++; if (seen !== 4'd3) begin errors++; $display("FAIL clr_data got=%0d exp=3", seen); end
    win4(16'h0003, 1'b0);
    for (int i = 0; i < 3; i++) step4(1'b1, 1'b0, 1'b1, 1'b0);
    step4(1'b1, 1'b1, 1'b1, 1'b0);
    checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL clr_hold_valid got=%b exp=1", valid4); end
    checks++; if (data4 !== 4'd2) begin errors++; $display("FAIL clr_hold_data got=%0d exp=2", data4); end
    checks++; if (busy4 !== 1'b0) begin errors++; $display("FAIL clr_hold_busy got=%b exp=0", busy4); end
    step4(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL clr_drain got=%b exp=0", valid4); end
  endtask

  task automatic test_collide_ready;
    logic [15:0] pat;
    pat = 16'h001F;
    win4(16'h0007, 1'b0);
    for (int i = 0; i < 15; i++) begin
      step4(1'b1, 1'b0, pat[i], 1'b0);
      if (i == 7) begin
        checks++; if (data4 !== 4'd3 || valid4 !== 1'b1) begin
          errors++; $display("FAIL col_hold got=%0d/%b exp=3/1", data4, valid4);
        end
      end
    end
    step4(1'b1, 1'b0, pat[15], 1'b1);
    checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL col_valid got=%b exp=1", valid4); end
    checks++; if (data4 !== 4'd5) begin errors++; $display("FAIL col_data got=%0d exp=5", data4); end
    checks++; if (ovf4 !== 1'b0) begin errors++; $display("FAIL col_ovf got=%b exp=0", ovf4); end
    step4(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL col_drain got=%b exp=0", valid4); end
  endtask

  task automatic test_overflow_reset;
    win4(16'h003F, 1'b0);
    checks++; if (data4 !== 4'd6 || ovf4 !== 1'b0) begin errors++; $display("FAIL ovf_first got=%0d/%b exp=6/0", data4, ovf4); end
    win4(16'h01FF, 1'b0);
    checks++; if (data4 !== 4'd9) begin errors++; $display("FAIL ovf_data got=%0d exp=9", data4); end
    checks++; if (valid4 !== 1'b1) begin errors++; $display("FAIL ovf_valid got=%b exp=1", valid4); end
    checks++; if (ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_flag got=%b exp=1", ovf4); end
    step4(1'b0, 1'b0, 1'b0, 1'b1);
    checks++; if (valid4 !== 1'b0) begin errors++; $display("FAIL ovf_drain got=%b exp=0", valid4); end
    checks++; if (ovf4 !== 1'b1) begin errors++; $display("FAIL ovf_sticky got=%b exp=1", ovf4); end
    for (int i = 0; i < 4; i++) step4(1'b1, 1'b0, 1'b1, 1'b1);
    rst4 = 1'b1;
    step4(1'b1, 1'b0, 1'b1, 1'b1);
    rst4 = 1'b0;
    checks++; if (data4 !== 4'd0 || valid4 !== 1'b0 || ovf4 !== 1'b0 || busy4 !== 1'b0) begin
      errors++; $display("FAIL midrst got=%0d/%b/%b/%b exp=0/0/0/0", data4, valid4, ovf4, busy4);
    end
    win4(16'h07FF, 1'b1);
    checks++; if (data4 !== 4'd11 || valid4 !== 1'b1) begin errors++; $display("FAIL postrst got=%0d/%b exp=11/1", data4, valid4); end
    checks++; if (ovf4 !== 1'b0) begin errors++; $display("FAIL postrst_ovf got=%b exp=0", ovf4); end
  endtask

  task automatic test_end_to_end;
    int vals [3];
    vals = '{100, 0, 255};
    for (int v = 0; v < 3; v++) begin
      for (int i = 0; i < 256; i++) begin
        step8(1'b1, (vals[v] > int'(sobol8(i))), 1'b1);
        if (i == 254) begin
          checks++; if (valid8 !== 1'b0) begin errors++; $display("FAIL e2e_early val=%0d got=%b exp=0", vals[v], valid8); end
        end
      end
      checks++; if (valid8 !== 1'b1) begin errors++; $display("FAIL e2e_valid val=%0d got=%b exp=1", vals[v], valid8); end
      checks++; if (data8 !== 8'(vals[v])) begin errors++; $display("FAIL e2e_data got=%0d exp=%0d", data8, vals[v]); end
    end
    checks++; if (ovf8 !== 1'b0) begin errors++; $display("FAIL e2e_ovf got=%b exp=0", ovf8); end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_back_to_back();
    test_enable_gaps();
    test_clear();
    test_collide_ready();
    test_overflow_reset();
    test_end_to_end();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
